scm_burst_reader: RTL and testbench
===================================

# scm_burst_reader

Read-side client for the latch-based standard-cell memory register files. It accepts a burst command with a start address and a beat count. It issues one-beat-per-cycle `ReadEnable`/`ReadAddr` requests to the SCM read port. It captures the wide read data the cycle after each request and returns it as a valid/ready stream with a last flag. It sits between an SCM instance and a streaming consumer, such as a DMA or an accelerator operand fetcher, and hides the SCM's address-register read latency behind a small credit-managed output buffer.

## Interface
Parameters:
- `RADDR_WIDTH`, 4: SCM read address width.
- `RDATA_WIDTH`, 128: SCM read data width, equal to stream width.
- `LEN_WIDTH`, `RADDR_WIDTH`: width of the burst length field, which is beats minus one.
- `FIFO_DEPTH`, 2: output buffer entries; minimum 2; 2 sustains full throughput.

Ports:
- `clk`  in  1  clock; single clock domain.
- `rst`  in  1  reset; synchronous, active-high.
- `cmd_valid_i`  in  1  burst command valid.
- `cmd_ready_o`  out  1  command accepted when both valid and ready are high.
- `cmd_addr_i`  in  `RADDR_WIDTH`  first read address.
- `cmd_len_i`  in  `LEN_WIDTH`  number of beats minus one.
- `ReadEnable_o`  out  1  SCM read request; the SCM registers the address on this cycle's edge.
- `ReadAddr_o`  out  `RADDR_WIDTH`  SCM read address; don't-care when `ReadEnable_o` is low.
- `ReadData_i`  in  `RDATA_WIDTH`  SCM read data; valid the cycle after `ReadEnable_o` and held until the next request.
- `rdata_valid_o`  out  1  stream beat valid.
- `rdata_ready_i`  in  1  stream beat accepted.
- `rdata_o`  out  `RDATA_WIDTH`  beat data.
- `rdata_last_o`  out  1  final beat of the burst.
- `busy_o`  out  1  a burst is in progress, not yet fully delivered.

## Operation
- FSM states:
  - IDLE: `cmd_ready_o`=1. On handshake, latch the address and remaining = len+1, then go to ISSUE.
  - ISSUE: issue one request per cycle while credit is available. The issue increments the address and decrements remaining. When the issuing beat has remaining==1, go to DRAIN.
  - DRAIN: wait until the buffer is empty and no request is in flight, then go to IDLE.
- `cmd_ready_o` is 0 outside IDLE. Commands presented during a busy burst are not accepted and stay pending.
- Credit rule: issue when occupancy + inflight − pop < `FIFO_DEPTH`.
  - inflight is the 1-bit flag "request issued last cycle".
  - pop = `rdata_valid_o` & `rdata_ready_i` in the current cycle.
- Capture: in the cycle after each request, push `ReadData_i` into the buffer unconditionally; the credit rule guarantees space.
- Last tagging: the beat issued with remaining==1 carries last=1 through the buffer.
- Address arithmetic: the address increments by 1 modulo 2^`RADDR_WIDTH`; wrap-around is silent and legal.
- `busy_o` = (state != IDLE).

## Timing
- Reset values: `cmd_ready_o`=0 during reset and 1 in the first cycle after reset. All of these are 0: `ReadEnable_o`, `rdata_valid_o`, `rdata_last_o`, `busy_o`. The buffer is empty, inflight=0, state=IDLE.
- For a command accepted at cycle T:
  - first `ReadEnable_o` at T+1;
  - data captured at the end of T+2;
  - `rdata_valid_o` high at T+3.
- With `rdata_ready_i` held at 1, beats appear on consecutive cycles. Burst latency is (len+1)+2 cycles from accept to last handshake.
- `cmd_ready_o` reasserts the cycle after the last beat handshakes.
- `rdata_o`/`rdata_last_o` stay stable while `rdata_valid_o`=1 and `rdata_ready_i`=0, and `rdata_valid_o` does not drop.
- `ReadEnable_o` is never asserted in IDLE or DRAIN.
- Reset mid-burst: the next cycle is in the reset state. In-flight and buffered beats are discarded, and no partial last is emitted.
- A pop and a capture in the same cycle are both honoured; occupancy is unchanged.

## Structure
- Package `scm_burst_reader_pkg`:
  - state enum `rd_state_e` {IDLE, ISSUE, DRAIN};
  - a function computing the credit condition.
- Sub-module `scm_burst_reader_fifo`: synchronous `FIFO_DEPTH`-entry buffer of {last, data}, with push/pop, occupancy output, and `rst`.
- The top level holds the FSM, address and remaining counters, inflight flag, and SCM port drive.

## Test plan
- Single beat: addr=5, len=0, ready=1 → one `ReadEnable_o` with `ReadAddr_o`=5 at T+1; beat = Mem[5] with last=1 at T+3; `cmd_ready_o`=1 at T+4.
- Streaming: addr=2, len=3, ready=1 → `ReadAddr_o` 2,3,4,5 on T+1..T+4; beats on T+3..T+6; last only on the T+6 beat.
- Backpressure: len=7 with ready toggling 1,0,0,1,…
  - data, order and last are preserved;
  - buffer occupancy never exceeds 2;
  - no `ReadEnable_o` without credit;
  - the output is stable while stalled.
- Wrap: addr=15, len=2, `RADDR_WIDTH`=4 → addresses 15,0,1 and beats Mem[15],Mem[0],Mem[1].
- Reset mid-burst: assert `rst` one cycle during beat 3 of len=7 → all outputs 0, no further beats. A new command (addr=0, len=0) returns Mem[0] with correct latency.
- Command while busy: hold `cmd_valid_i` through a burst → `cmd_ready_o` stays 0 until the burst completes. The second command is then accepted, and its beats follow without loss.

Source files
------------

// File: rtl/scm_burst_reader_pkg.sv
// Shared types and helpers for the SCM burst reader.
// No logic of its own; pure declarations.
// Credit helper decides whether a new SCM request fits in the output buffer.
package scm_burst_reader_pkg;

    typedef enum logic [1:0] {
        RD_IDLE  = 2'd0,
        RD_ISSUE = 2'd1,
        RD_DRAIN = 2'd2
    } rd_state_e;

    // A request may go out only if every beat already owed to the buffer,
    // less the one leaving this cycle, still leaves a free slot.
    function automatic logic credit_ok(input int occ, input int inflight,
                                       input int pop, input int depth);
        return (occ + inflight - pop) < depth;
    endfunction

endpackage

// File: rtl/scm_burst_reader_fifo.sv
// Small synchronous buffer of {last, data} beats between SCM capture and stream.
// Latency: a pushed beat is visible on pop_dat_o the following cycle.
// Backpressure: none internally; the caller's credit check keeps pushes in bounds.
module scm_burst_reader_fifo #(
    parameter int WIDTH = 129,
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           push_dat_i,
    input  logic                       pop_i,
    output logic [WIDTH-1:0]           pop_dat_o,
    output logic [$clog2(DEPTH+1)-1:0] occ_o
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = $clog2(DEPTH + 1);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
    localparam logic [OCC_W-1:0] OCC_ONE  = OCC_W'(1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [OCC_W-1:0] occ_q;

    // Beat storage; contents only matter while occupancy covers them.
    always_ff @(posedge clk) begin
        if (push_i) begin
            mem_q[wr_ptr_q] <= push_dat_i;
        end
    end

    // Pointer and occupancy bookkeeping; simultaneous push and pop keep occupancy.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
        end else begin
            if (push_i) begin
                wr_ptr_q <= (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + PTR_ONE;
            end
            if (pop_i) begin
                rd_ptr_q <= (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + PTR_ONE;
            end
            if (push_i && !pop_i) begin
                occ_q <= occ_q + OCC_ONE;
            end else if (!push_i && pop_i) begin
                occ_q <= occ_q - OCC_ONE;
            end
        end
    end

    assign pop_dat_o = mem_q[rd_ptr_q];
    assign occ_o     = occ_q;

endmodule

// File: rtl/scm_burst_reader.sv
// Burst read client for an SCM register file: issues one read per cycle, streams beats out.
// Latency: command accepted at T -> first request T+1 -> first beat valid T+3.
// Backpressure: stream ready stalls issue via credit; commands wait while a burst is active.
module scm_burst_reader #(
    parameter int RADDR_WIDTH = 4,
    parameter int RDATA_WIDTH = 128,
    parameter int LEN_WIDTH   = RADDR_WIDTH,
    parameter int FIFO_DEPTH  = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   cmd_valid_i,
    output logic                   cmd_ready_o,
    input  logic [RADDR_WIDTH-1:0] cmd_addr_i,
    input  logic [LEN_WIDTH-1:0]   cmd_len_i,
    output logic                   ReadEnable_o,
    output logic [RADDR_WIDTH-1:0] ReadAddr_o,
    input  logic [RDATA_WIDTH-1:0] ReadData_i,
    output logic                   rdata_valid_o,
    input  logic                   rdata_ready_i,
    output logic [RDATA_WIDTH-1:0] rdata_o,
    output logic                   rdata_last_o,
    output logic                   busy_o
);
    import scm_burst_reader_pkg::*;

    localparam int OCC_W = $clog2(FIFO_DEPTH + 1);
    localparam logic [RADDR_WIDTH-1:0] ADDR_ONE = RADDR_WIDTH'(1);
    localparam logic [LEN_WIDTH:0]     REM_ONE  = (LEN_WIDTH + 1)'(1);

    rd_state_e              state_q, state_d;
    logic [RADDR_WIDTH-1:0] addr_q, addr_d;
    logic [LEN_WIDTH:0]     rem_q, rem_d;
    logic                   inflight_q, inflight_last_q;
    logic [OCC_W-1:0]       occ;
    logic [RDATA_WIDTH:0]   fifo_dat;
    logic                   pop, issue, last_issue;

    assign pop        = rdata_valid_o & rdata_ready_i;
    // Reset gating keeps the SCM quiet and refuses commands while rst is held.
    assign issue      = (state_q == RD_ISSUE) && !rst &&
                        credit_ok(int'(occ), int'(inflight_q), int'(pop), FIFO_DEPTH);
    assign last_issue = issue && (rem_q == REM_ONE);

    assign cmd_ready_o   = (state_q == RD_IDLE) && !rst;
    assign ReadEnable_o  = issue;
    assign ReadAddr_o    = addr_q;
    assign busy_o        = (state_q != RD_IDLE);
    assign rdata_valid_o = (occ != '0);
    assign rdata_o       = fifo_dat[RDATA_WIDTH-1:0];
    assign rdata_last_o  = rdata_valid_o & fifo_dat[RDATA_WIDTH];

    // Burst sequencing: latch command, walk the address range, then wait for delivery.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        rem_d   = rem_q;
        unique case (state_q)
            RD_IDLE: begin
                if (cmd_valid_i && cmd_ready_o) begin
                    addr_d  = cmd_addr_i;
                    rem_d   = {1'b0, cmd_len_i} + REM_ONE;
                    state_d = RD_ISSUE;
                end
            end
            RD_ISSUE: begin
                if (issue) begin
                    addr_d = addr_q + ADDR_ONE;
                    rem_d  = rem_q - REM_ONE;
                    if (rem_q == REM_ONE) begin
                        state_d = RD_DRAIN;
                    end
                end
            end
            RD_DRAIN: begin
                // Leave as the final beat pops so a new command is taken the next cycle.
                if (!inflight_q && (occ == {{(OCC_W-1){1'b0}}, pop})) begin
                    state_d = RD_IDLE;
                end
            end
            default: state_d = RD_IDLE;
        endcase
    end

    // State registers plus the one-cycle SCM read latency tracker.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= RD_IDLE;
            addr_q          <= '0;
            rem_q           <= '0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            addr_q          <= addr_d;
            rem_q           <= rem_d;
            inflight_q      <= issue;
            inflight_last_q <= last_issue;
        end
    end

    // Data returned by the SCM the cycle after a request is captured unconditionally.
    scm_burst_reader_fifo #(
        .WIDTH (RDATA_WIDTH + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push_i     (inflight_q),
        .push_dat_i ({inflight_last_q, ReadData_i}),
        .pop_i      (pop),
        .pop_dat_o  (fifo_dat),
        .occ_o      (occ)
    );

endmodule

// File: tb/tb_scm_burst_reader.sv
// Bench for scm_burst_reader: directed timing cases plus randomized bursts.
// A queue-based model predicts addresses and beats from each accepted command.
// Every cycle the monitor compares DUT ports against that model.
module tb_scm_burst_reader;
    localparam int AW = 4;
    localparam int DW = 128;
    localparam int LW = 4;
    localparam int DEPTH = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          cmd_valid_i = 1'b0;
    logic          cmd_ready_o;
    logic [AW-1:0] cmd_addr_i = '0;
    logic [LW-1:0] cmd_len_i = '0;
    logic          ReadEnable_o;
    logic [AW-1:0] ReadAddr_o;
    logic [DW-1:0] ReadData_i;
    logic          rdata_valid_o;
    logic          rdata_ready_i = 1'b1;
    logic [DW-1:0] rdata_o;
    logic          rdata_last_o;
    logic          busy_o;

    scm_burst_reader #(
        .RADDR_WIDTH (AW),
        .RDATA_WIDTH (DW),
        .LEN_WIDTH   (LW),
        .FIFO_DEPTH  (DEPTH)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .cmd_valid_i   (cmd_valid_i),
        .cmd_ready_o   (cmd_ready_o),
        .cmd_addr_i    (cmd_addr_i),
        .cmd_len_i     (cmd_len_i),
        .ReadEnable_o  (ReadEnable_o),
        .ReadAddr_o    (ReadAddr_o),
        .ReadData_i    (ReadData_i),
        .rdata_valid_o (rdata_valid_o),
        .rdata_ready_i (rdata_ready_i),
        .rdata_o       (rdata_o),
        .rdata_last_o  (rdata_last_o),
        .busy_o        (busy_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // SCM read port: address registered on a request, data held until the next one.
    logic [DW-1:0] mem [16];
    logic [DW-1:0] scm_q = '0;
    always @(posedge clk) if (ReadEnable_o) scm_q <= mem[ReadAddr_o];
    assign ReadData_i = scm_q;

    int checks = 0;
    int fails  = 0;

    task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] want);
        checks++;
        if (act !== want) begin
            fails++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, want, cyc);
        end
    endtask

    // Behavioural model: expected addresses and beats per accepted command.
    typedef struct packed { logic l; logic [DW-1:0] d; } beat_t;
    beat_t         exp_q[$];
    logic [AW-1:0] addr_exp[$];
    bit            m_busy = 0;
    int            outstanding = 0;
    bit            prev_stall = 0;
    logic [DW-1:0] prev_d;
    logic          prev_l;

    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            addr_exp.delete();
            m_busy = 0;
            outstanding = 0;
            prev_stall = 0;
        end else begin
            chk("busy", busy_o, m_busy);
            chk("cmd_ready", cmd_ready_o, !m_busy);
            if (ReadEnable_o) begin
                if (addr_exp.size() == 0) chk("issue_without_pending", ReadEnable_o, 0);
                else chk("read_addr", ReadAddr_o, addr_exp.pop_front());
                outstanding++;
            end
            if (prev_stall) begin
                chk("stall_valid", rdata_valid_o, 1);
                chk("stall_data", rdata_o, prev_d);
                chk("stall_last", rdata_last_o, prev_l);
            end
            if (rdata_valid_o && rdata_ready_i) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_beat", rdata_valid_o, 0);
                end else begin
                    beat_t b;
                    b = exp_q.pop_front();
                    chk("beat_data", rdata_o, b.d);
                    chk("beat_last", rdata_last_o, b.l);
                    outstanding--;
                    if (b.l) m_busy = 0;
                end
            end
            chk("credit_bound", outstanding <= DEPTH, 1);
            prev_stall = rdata_valid_o && !rdata_ready_i;
            prev_d = rdata_o;
            prev_l = rdata_last_o;
            if (cmd_valid_i && cmd_ready_o) begin
                for (int i = 0; i <= int'(cmd_len_i); i++) begin
                    beat_t nb;
                    int a;
                    a = (int'(cmd_addr_i) + i) % 16;
                    nb.d = mem[a];
                    nb.l = (i == int'(cmd_len_i));
                    exp_q.push_back(nb);
                    addr_exp.push_back(AW'(a));
                end
                m_busy = 1;
            end
        end
    end

    // Stream ready driver: 0 = always ready, 1 = 1,0,0 repeating, 2 = random.
    int rmode = 0;
    int rphase = 0;
    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (rmode)
                0: rdata_ready_i = 1'b1;
                1: begin rdata_ready_i = (rphase % 3 == 0); rphase++; end
                default: rdata_ready_i = ($urandom_range(0, 3) != 0);
            endcase
        end
    end

    // Called at posedge+1; returns at posedge+1 of the cycle after acceptance.
    task automatic send_cmd(input int a, input int l, input bit hold, output int t_acc);
        cmd_valid_i = 1'b1;
        cmd_addr_i = AW'(a);
        cmd_len_i = LW'(l);
        t_acc = -1;
        for (int k = 0; k < 400; k++) begin
            @(negedge clk);
            if (cmd_ready_o) begin
                t_acc = cyc;
                break;
            end
        end
        if (t_acc < 0) chk("cmd_accept_timeout", cmd_ready_o, 1);
        @(posedge clk);
        #1;
        if (!hold) cmd_valid_i = 1'b0;
    endtask

    task automatic wait_idle();
        bit done;
        done = 0;
        for (int k = 0; k < 600 && !done; k++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !m_busy && !busy_o) done = 1;
        end
        if (!done) chk("drain_timeout", busy_o, 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int t, t2, gap;
        for (int i = 0; i < 16; i++) mem[i] = {32'hDEAD0000 + 32'(i), $urandom, $urandom, $urandom};

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_cmd_ready", cmd_ready_o, 0);
        chk("rst_read_en", ReadEnable_o, 0);
        chk("rst_valid", rdata_valid_o, 0);
        chk("rst_busy", busy_o, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("post_rst_cmd_ready", cmd_ready_o, 1);
        chk("post_rst_last", rdata_last_o, 0);
        chk("post_rst_valid", rdata_valid_o, 0);
        @(posedge clk);
        #1;

        // Single beat: addr 5, len 0
        send_cmd(5, 0, 0, t);
        @(negedge clk);
        chk("single_re_t1", ReadEnable_o, 1);
        chk("single_addr_t1", ReadAddr_o, 5);
        @(negedge clk);
        chk("single_valid_t2", rdata_valid_o, 0);
        chk("single_re_t2", ReadEnable_o, 0);
        @(negedge clk);
        chk("single_valid_t3", rdata_valid_o, 1);
        chk("single_tag_t3", rdata_o[127:96], 32'hDEAD0005);
        chk("single_data_t3", rdata_o, mem[5]);
        chk("single_last_t3", rdata_last_o, 1);
        @(negedge clk);
        chk("single_cmd_ready_t4", cmd_ready_o, 1);
        @(posedge clk);
        #1;

        // Streaming: addr 2, len 3
        send_cmd(2, 3, 0, t);
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            chk("stream_re", ReadEnable_o, k <= 4);
            if (k <= 4) chk("stream_addr", ReadAddr_o, 2 + k - 1);
            chk("stream_valid", rdata_valid_o, k >= 3);
            chk("stream_last", rdata_last_o, k == 6);
        end
        @(negedge clk);
        chk("stream_cmd_ready_t7", cmd_ready_o, 1);
        @(posedge clk);
        #1;

        // Wrap: addr 15, len 2
        send_cmd(15, 2, 0, t);
        @(negedge clk);
        chk("wrap_addr0", ReadAddr_o, 15);
        @(negedge clk);
        chk("wrap_addr1", ReadAddr_o, 0);
        @(negedge clk);
        chk("wrap_addr2", ReadAddr_o, 1);
        wait_idle();

        // Backpressure: len 7 with a 1,0,0 ready pattern
        rmode = 1;
        send_cmd(6, 7, 0, t);
        wait_idle();
        rmode = 0;
        repeat (2) @(posedge clk);
        #1;

        // Reset during beat 3 of a len 7 burst
        send_cmd(8, 7, 0, t);
        repeat (4) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("midrst_valid", rdata_valid_o, 0);
        chk("midrst_last", rdata_last_o, 0);
        chk("midrst_re", ReadEnable_o, 0);
        chk("midrst_busy", busy_o, 0);
        chk("midrst_cmd_ready", cmd_ready_o, 1);
        repeat (5) begin
            @(negedge clk);
            chk("midrst_no_beats", rdata_valid_o, 0);
        end
        @(posedge clk);
        #1;
        send_cmd(0, 0, 0, t);
        @(negedge clk);
        chk("after_rst_addr", ReadAddr_o, 0);
        @(negedge clk);
        @(negedge clk);
        chk("after_rst_valid_t3", rdata_valid_o, 1);
        chk("after_rst_data_t3", rdata_o, mem[0]);
        chk("after_rst_last_t3", rdata_last_o, 1);
        wait_idle();

        // Command held during a busy burst
        send_cmd(3, 5, 1, t);
        send_cmd(10, 2, 0, t2);
        chk("busy_cmd_accept_delay", t2 - t, 9);
        wait_idle();

        // Randomized bursts with random ready and random gaps
        rmode = 2;
        repeat (40) begin
            gap = $urandom_range(0, 3);
            repeat (gap) begin
                @(posedge clk);
                #1;
            end
            send_cmd($urandom_range(0, 15), $urandom_range(0, 15), 0, t);
            if ($urandom_range(0, 1) == 1) wait_idle();
        end
        wait_idle();

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
